fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default sizes
// and the PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;

    localparam int unsigned INSTR_W_DEF    = 28;
    localparam int unsigned PROG_WORDS_DEF = 9;
    localparam int unsigned PC_STEP        = 4;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a PROG_WORDS-word program into a one-entry
// valid/ready output register. Optional FETCH_PERF_EN adds an accept counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PROG_WORDS = PROG_WORDS_DEF,
    parameter int unsigned INSTR_W    = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic [31:0]        imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               branch_i,
    input  logic [31:0]        branch_target_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               done_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count_o
`endif
);

    fetch_state_t       state, state_next;
    logic [31:0]        pc, pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic [31:0]        pc_out_next;
    logic               valid_next;

    assign imem_addr_o = pc;
    assign done_o      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            instr_o <= '0;
            pc_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            instr_o <= instr_next;
            pc_o    <= pc_out_next;
            valid_o <= valid_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr_o;
        pc_out_next = pc_o;
        valid_next  = valid_o;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    pc_next    = '0;
                    valid_next = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (branch_i) begin
                    pc_next    = branch_target_i & ~32'd3;
                    valid_next = 1'b0;
                end else if (word_index(pc) >= 30'(PROG_WORDS)) begin
                    state_next = DRAIN;
                end else if (!valid_o || ready_i) begin
                    instr_next  = imem_instr_i;
                    pc_out_next = pc;
                    valid_next  = 1'b1;
                    // Last word: PC parks on it so imem_addr_o stays in range.
                    if (word_index(pc) == 30'(PROG_WORDS - 1))
                        state_next = DRAIN;
                    else
                        pc_next = pc + 32'(PC_STEP);
                end
            end
            DRAIN: begin
                if (valid_o && ready_i)
                    valid_next = 1'b0;
                else if (!valid_o)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [31:0] count, count_next;

    assign fetch_count_o = count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

    always_comb begin
        count_next = count;
        if (start_i && (state == IDLE || state == DONE))
            count_next = '0;
        else if (valid_o && ready_i && count != '1)
            count_next = count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_fetch_unit;

    localparam int unsigned PW = 9;

    logic        clk = 1'b0;
    logic        reset, start_i, branch_i, ready_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o, pc_o;
    logic [27:0] imem_instr_i, instr_o;
    logic        valid_o, done_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_o;
`endif

    always #5 clk = ~clk;

    function automatic logic [27:0] imem_word(input logic [31:0] addr);
        logic [31:0] h;
        h = {6'd0, addr[27:2]} * 32'h9E37_79B1 + 32'h0123_4567;
        return h[27:0];
    endfunction

    assign imem_instr_i = imem_word(imem_addr_o);

    fetch_unit #(.PROG_WORDS(PW), .INSTR_W(28)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .imem_addr_o     (imem_addr_o),
        .imem_instr_i    (imem_instr_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .done_o          (done_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o   (fetch_count_o)
`endif
    );

    // Model: mode 0=idle 1=fetching 2=draining 3=finished
    int          m_mode;
    logic [31:0] m_pc, m_pco, m_cnt;
    logic [27:0] m_instr;
    bit          m_valid;

    bit          chk_on = 0;
    bit          pin_en = 0, pin_pc_en, pin_valid, pin_done, pin_cnt_en;
    logic [31:0] pin_pc, pin_cnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("imem_addr", imem_addr_o, m_pc);
            chk("instr", {4'd0, instr_o}, {4'd0, m_instr});
            chk("pc", pc_o, m_pco);
            chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
            chk("done", {31'd0, done_o}, {31'd0, m_mode == 3});
`ifdef FETCH_PERF_EN
            chk("count", fetch_count_o, m_cnt);
`endif
        end
        if (pin_en) begin
            chk("lit_model_valid", {31'd0, m_valid}, {31'd0, pin_valid});
            chk("lit_valid", {31'd0, valid_o}, {31'd0, pin_valid});
            chk("lit_done", {31'd0, done_o}, {31'd0, pin_done});
            if (pin_pc_en) begin
                chk("lit_model_pc", m_pco, pin_pc);
                chk("lit_pc", pc_o, pin_pc);
            end
`ifdef FETCH_PERF_EN
            if (pin_cnt_en) chk("lit_count", fetch_count_o, pin_cnt);
`endif
        end
    end

    // One clock: apply inputs, advance the model by the stated rules.
    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit rd);
        int          n_mode;
        logic [31:0] n_pc, n_pco, n_cnt;
        logic [27:0] n_instr;
        bit          n_valid;
        @(negedge clk);
        #1;
        pin_en = 0;
        reset = r; start_i = s; branch_i = b; branch_target_i = t; ready_i = rd;
        n_mode = m_mode; n_pc = m_pc; n_pco = m_pco; n_instr = m_instr;
        n_valid = m_valid; n_cnt = m_cnt;
        if (r) begin
            n_mode = 0; n_pc = 0; n_pco = 0; n_instr = 0; n_valid = 0; n_cnt = 0;
        end else begin
            if ((m_mode == 0 || m_mode == 3) && s) n_cnt = 0;
            else if (m_valid && rd && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
            if (m_mode == 0 || m_mode == 3) begin
                if (s) begin n_pc = 0; n_valid = 0; n_mode = 1; end
            end else if (m_mode == 1) begin
                if (b) begin
                    n_pc = t - (t % 4); n_valid = 0;
                end else if (m_pc / 4 >= PW) begin
                    n_mode = 2;
                end else if (!m_valid || rd) begin
                    n_instr = imem_word(m_pc); n_pco = m_pc; n_valid = 1;
                    if (m_pc / 4 == PW - 1) n_mode = 2;
                    else n_pc = m_pc + 4;
                end
            end else begin
                if (m_valid && rd) n_valid = 0;
                else if (!m_valid) n_mode = 3;
            end
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_pco = n_pco; m_instr = n_instr;
        m_valid = n_valid; m_cnt = n_cnt;
    endtask

    task automatic pin(input bit pc_en, input logic [31:0] pc, input bit v, input bit d);
        pin_pc_en = pc_en; pin_pc = pc; pin_valid = v; pin_done = d;
        pin_cnt_en = 0; pin_cnt = 0;
        pin_en = 1;
    endtask

    initial begin
        reset = 1; start_i = 0; branch_i = 0; branch_target_i = 0; ready_i = 0;
        m_mode = 0; m_pc = 0; m_pco = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_on = 1;
        pin(1, 0, 0, 0);

        // Full program with ready held high
        step(0, 1, 0, 0, 1); pin(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 0, 1); pin(1, 32'(i * 4), 1, 0);
        end
        step(0, 0, 0, 0, 1); pin(1, 32, 0, 0);
        step(0, 0, 0, 0, 1); pin(1, 32, 0, 1);

        // Stall at pc 8
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1); pin(1, 32'(i * 4), 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0); pin(1, 8, 1, 0);
        end
        step(0, 0, 0, 0, 1); pin(1, 12, 1, 0);

        // Branch to 0x13 while pc_o=4, then out-of-range branch to 0x40
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1); pin(1, 0, 1, 0);
        step(0, 0, 0, 0, 1); pin(1, 4, 1, 0);
        step(0, 0, 1, 32'h13, 1); pin(1, 4, 0, 0);
        step(0, 0, 0, 0, 1); pin(1, 32'h10, 1, 0);
        step(0, 0, 1, 32'h40, 1); pin(0, 0, 0, 0);
        step(0, 0, 0, 0, 1); pin(0, 0, 0, 0);
        step(0, 0, 0, 0, 1); pin(0, 0, 0, 1);
        step(0, 0, 0, 0, 1); pin(0, 0, 0, 1);

        // Mid-run reset at pc_o=16, then restart
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1); pin(1, 32'(i * 4), 1, 0);
        end
        step(1, 1, 1, 32'h8, 1); pin(1, 0, 0, 0);
        step(0, 1, 0, 0, 1); pin(1, 0, 0, 0);
        step(0, 0, 0, 0, 1); pin(1, 0, 1, 0);

`ifdef FETCH_PERF_EN
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 30 && m_mode != 3; i++)
            step(0, 0, 0, 0, (i == 3 || i == 4) ? 1'b0 : 1'b1);
        pin(0, 0, 0, 1);
        pin_cnt_en = 1; pin_cnt = 9;
`endif

        // Randomized traffic
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 11) == 0) ? $urandom : $urandom_range(0, 47);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 19) == 0, t, $urandom_range(0, 9) < 7);
        end
        step(0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
